// File: rtl/cnn_pkg.sv
// cnn_pkg: shared types and float constants for the CNN datapath
package cnn_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} streamer_state_t;
  localparam logic [31:0] FLOAT_ZERO = 32'h0000_0000;
  localparam logic [31:0] FLOAT_TEN = 32'h4120_0000;
  function automatic int cnt_width(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/image_streamer_if.sv
// image_streamer_if: control, memory read and stream signals of the frame source
interface image_streamer_if #(parameter int DATA_WIDTH = 32, parameter int ADDR_WIDTH = 10);
  logic start;
  logic stall;
  logic mem_rden;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [DATA_WIDTH-1:0] data_out;
  logic data_fifo_wren;
  logic busy;
  logic done;
  modport master (input start, stall, mem_rdata, output mem_rden, mem_addr, data_out, data_fifo_wren, busy, done);
  modport slave (output start, stall, mem_rdata, input mem_rden, mem_addr, data_out, data_fifo_wren, busy, done);
endinterface

// File: rtl/image_streamer_raster_counter.sv
// raster_counter: row/col position counters with enable, wrap and last-position flag
module raster_counter import cnn_pkg::*; #(
  parameter int OW = 7,
  parameter int OH = 7,
  parameter int CW = cnt_width(OW),
  parameter int RW = cnt_width(OH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_en,
  output logic [CW-1:0] o_col,
  output logic [RW-1:0] o_row,
  output logic          o_last
);
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic w_col_end, w_row_end;
  assign w_col_end = r_col == CW'(OW - 1);
  assign w_row_end = r_row == RW'(OH - 1);
  assign o_last = w_col_end && w_row_end;
  assign o_col = r_col;
  assign o_row = r_row;
  always_ff @(posedge clk)
    if (!rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_en) begin
      r_col <= w_col_end ? '0 : r_col + 1'b1;
      if (w_col_end) r_row <= w_row_end ? '0 : r_row + 1'b1;
    end
endmodule

// File: rtl/image_streamer.sv
// image_streamer: raster frame source with optional zero border, feeding conv2D
module image_streamer import cnn_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int WIDTH = 5,
  parameter int HEIGHT = 5,
  parameter int PAD = 1,
  parameter int ADDR_WIDTH = 10
) (
  input logic clk,
  input logic rst,
  image_streamer_if.master bus
);
  localparam int OW = WIDTH + 2 * PAD;
  localparam int OH = HEIGHT + 2 * PAD;
  localparam int CW = cnt_width(OW);
  localparam int RW = cnt_width(OH);
  streamer_state_t r_state, w_next;
  logic [CW-1:0] w_col;
  logic [RW-1:0] w_row;
  logic w_last, w_issue, w_int, w_rden;
  int w_r, w_c;
  logic [ADDR_WIDTH-1:0] w_addr, r_addr;
  logic r_valid, r_pad, r_done;
  raster_counter #(.OW(OW), .OH(OH), .CW(CW), .RW(RW)) u_cnt (
    .clk(clk), .rst(rst), .i_en(w_issue), .o_col(w_col), .o_row(w_row), .o_last(w_last)
  );
  always_ff @(posedge clk) r_state <= !rst ? IDLE : w_next;
  always_comb begin
    w_issue = r_state == RUN && !bus.stall;
    w_next = r_state == IDLE ? (bus.start ? RUN : IDLE) :
             r_state == RUN ? (w_issue && w_last ? DRAIN : RUN) : IDLE;
  end
  always_comb begin
    w_r = int'(w_row);
    w_c = int'(w_col);
    w_int = w_r >= PAD && w_r < OH - PAD && w_c >= PAD && w_c < OW - PAD;
    w_rden = w_issue && w_int;
    w_addr = ADDR_WIDTH'((w_r - PAD) * WIDTH + w_c - PAD);
  end
  // r_pad also masks the stale read word whenever nothing was issued
  always_ff @(posedge clk)
    if (!rst) begin
      r_valid <= 1'b0;
      r_pad <= 1'b1;
      r_done <= 1'b0;
      r_addr <= '0;
    end else begin
      r_valid <= w_issue;
      r_pad <= !w_rden;
      r_done <= r_state == DRAIN;
      if (w_rden) r_addr <= w_addr;
    end
  assign bus.mem_rden = w_rden;
  assign bus.mem_addr = w_rden ? w_addr : r_addr;
  assign bus.data_fifo_wren = r_valid;
  assign bus.data_out = r_pad ? DATA_WIDTH'(FLOAT_ZERO) : bus.mem_rdata;
  assign bus.busy = r_state != IDLE;
  assign bus.done = r_done;
endmodule

// File: tb/tb_image_streamer.sv
// tb_image_streamer: table-driven frame checks for padded and unpadded streamers
module tb_image_streamer;
  import cnn_pkg::*;
  typedef struct {
    int dut, s_lo, s_hi, pulse, rst_at, budget;
    bit hold;
    int n_words, n_done, done_cyc, n_addr;
  } vec_t;
  logic clk = 0, rst_r = 0, start_r = 0, stall_r = 0;
  bit sel = 0;
  always #5 clk = ~clk;
  image_streamer_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) b0 ();
  image_streamer_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) b1 ();
  assign b0.start = start_r && !sel;
  assign b0.stall = stall_r && !sel;
  assign b1.start = start_r && sel;
  assign b1.stall = stall_r && sel;
  image_streamer u0 (.clk(clk), .rst(rst_r), .bus(b0));
  image_streamer #(.PAD(0)) u1 (.clk(clk), .rst(rst_r), .bus(b1));
  logic [31:0] m0 [0:1023];
  initial for (int i = 0; i < 1024; i++) m0[i] = i;
  always @(posedge clk) begin
    if (b0.mem_rden) b0.mem_rdata <= m0[b0.mem_addr];
    if (b1.mem_rden) b1.mem_rdata <= FLOAT_TEN;
  end
  int n_cmp = 0, n_bad = 0;
  logic [31:0] q_data[$];
  int q_wcyc[$], q_addr[$];
  int done_cnt, done_first, zero_bad;
  bit busy_log [0:99];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic int exp_word(input int dut, input int k);
    int r, c;
    if (dut != 0) return 32'h4120_0000;
    r = k / 7;
    c = k % 7;
    return (r >= 1 && r <= 5 && c >= 1 && c <= 5) ? (r - 1) * 5 + c - 1 : 0;
  endfunction
  function automatic int exp_cyc(input vec_t v, input int k);
    int c = 1;
    for (int j = 0; j <= k; j++) begin
      while (c >= v.s_lo && c <= v.s_hi) c++;
      if (j == k) return c + 1;
      c++;
    end
    return -1;
  endfunction
  task automatic run(input vec_t v);
    bit wr, rd, bz, dn;
    logic [31:0] d;
    logic [9:0] a;
    q_data.delete();
    q_wcyc.delete();
    q_addr.delete();
    done_cnt = 0;
    done_first = 0;
    zero_bad = 0;
    for (int i = 0; i < 100; i++) busy_log[i] = 0;
    sel = v.dut != 0;
    start_r = 1;
    stall_r = 0 >= v.s_lo && 0 <= v.s_hi;
    for (int c = 1; c <= v.budget; c++) begin
      @(posedge clk);
      #1;
      start_r = v.hold || c == v.pulse;
      stall_r = c >= v.s_lo && c <= v.s_hi;
      rst_r = c != v.rst_at;
      #1;
      wr = sel ? b1.data_fifo_wren : b0.data_fifo_wren;
      rd = sel ? b1.mem_rden : b0.mem_rden;
      bz = sel ? b1.busy : b0.busy;
      dn = sel ? b1.done : b0.done;
      d = sel ? b1.data_out : b0.data_out;
      a = sel ? b1.mem_addr : b0.mem_addr;
      if (wr) begin
        q_data.push_back(d);
        q_wcyc.push_back(c);
      end
      if (rd) q_addr.push_back(int'(a));
      busy_log[c] = bz;
      if (dn) begin
        done_cnt++;
        if (done_first == 0) done_first = c;
      end
      if (v.rst_at > 0 && c > v.rst_at && (wr || rd || bz || dn || d != 0 || a != 0)) zero_bad++;
    end
    @(posedge clk);
    #1;
    start_r = 0;
    stall_r = 0;
    rst_r = 0;
    @(posedge clk);
    #1;
    rst_r = 1;
  endtask
  vec_t tv [8];
  initial begin
    tv[0] = '{0, 0, -1, 0, 0, 60, 0, 49, 1, 51, 25};
    tv[1] = '{1, 0, -1, 0, 0, 35, 0, 25, 1, 27, 25};
    tv[2] = '{0, 5, 7, 0, 0, 60, 0, 49, 1, 54, 25};
    tv[3] = '{0, 0, -1, 20, 0, 60, 0, 49, 1, 51, 25};
    tv[4] = '{0, 0, -1, 0, 0, 52, 1, 49, 1, 51, 25};
    tv[5] = '{0, 0, -1, 0, 15, 60, 0, 14, 0, 0, 5};
    tv[6] = '{0, 0, -1, 0, 0, 60, 0, 49, 1, 51, 25};
    tv[7] = '{0, 0, 3, 0, 0, 60, 0, 49, 1, 54, 25};
    repeat (3) @(posedge clk);
    #1;
    chk("rst wren", {b0.data_fifo_wren, b1.data_fifo_wren}, 0);
    chk("rst data0", b0.data_out, 0);
    chk("rst data1", b1.data_out, 0);
    chk("rst rden", {b0.mem_rden, b1.mem_rden}, 0);
    chk("rst addr", {b0.mem_addr, b1.mem_addr}, 0);
    chk("rst busy/done", {b0.busy, b0.done, b1.busy, b1.done}, 0);
    rst_r = 1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      run(tv[i]);
      chk($sformatf("v%0d words", i), q_data.size(), tv[i].n_words);
      chk($sformatf("v%0d done count", i), done_cnt, tv[i].n_done);
      if (tv[i].n_done > 0) chk($sformatf("v%0d done cycle", i), done_first, tv[i].done_cyc);
      chk($sformatf("v%0d addr count", i), q_addr.size(), tv[i].n_addr);
      for (int k = 0; k < q_addr.size(); k++) chk($sformatf("v%0d addr%0d", i, k), q_addr[k], k);
      for (int k = 0; k < q_data.size() && k < tv[i].n_words; k++) begin
        chk($sformatf("v%0d word%0d", i, k), q_data[k], exp_word(tv[i].dut, k));
        chk($sformatf("v%0d cyc%0d", i, k), q_wcyc[k], exp_cyc(tv[i], k));
      end
      if (tv[i].rst_at > 0) chk($sformatf("v%0d zero after rst", i), zero_bad, 0);
      if (tv[i].hold) begin
        chk($sformatf("v%0d busy idle gap", i), busy_log[51], 0);
        chk($sformatf("v%0d busy relaunch", i), busy_log[52], 1);
      end
      if (tv[i].s_lo == 5 && q_wcyc.size() > 4) begin
        chk($sformatf("v%0d skid cyc", i), q_wcyc[3], 5);
        chk($sformatf("v%0d resume cyc", i), q_wcyc[4], 9);
      end
      if (tv[i].dut == 0 && q_data.size() == 49) begin
        chk($sformatf("v%0d w8", i), q_data[8], 0);
        chk($sformatf("v%0d w9", i), q_data[9], 1);
        chk($sformatf("v%0d w40", i), q_data[40], 24);
        chk($sformatf("v%0d w48", i), q_data[48], 0);
        chk($sformatf("v%0d busy first", i), busy_log[1], 1);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
